// File: rtl/lane_pack_pkg.sv
// Shared types and helpers for the lane packing deserializer.
package lane_pack_pkg;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

  // Counter width able to hold 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/lane_pack_out_reg.sv
// Output holding register: keeps the packed word and its word count stable
// until the sink takes it, and reports when a new word may be loaded.
module lane_pack_out_reg #(
  parameter int W  = 16,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          load_i,
  input  logic [W-1:0]  load_data_i,
  input  logic [CW-1:0] load_count_i,
  input  logic          out_ready_i,
  output logic          out_valid_o,
  output logic [W-1:0]  out_data_o,
  output logic [CW-1:0] out_count_o,
  output logic          out_free_o
);

  logic          valid_q, valid_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] count_q, count_d;

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_count_o = count_q;
  // Slot is free when empty or being drained this cycle.
  assign out_free_o  = !valid_q || out_ready_i;

  // Load wins over drain so a same-cycle refill keeps valid high; data only
  // changes on load so it is never cleared by a drain.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    count_d = count_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      count_d = load_count_i;
    end else if (valid_q && out_ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/lane_pack_deser.sv
// Packs DEPTH consecutive WIDTH-bit words (first word in the LSBs) into one
// wide word behind a valid/ready holding register.
// Optional early-close input in_last is enabled by defining LANE_PACK_FLUSH_EN.
module lane_pack_deser
  import lane_pack_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                        clk,
  input  logic                        arst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
`ifdef LANE_PACK_FLUSH_EN
  input  logic                        in_last,
`endif
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH*DEPTH-1:0]      out_data,
  output logic [cnt_w(DEPTH)-1:0]     out_count
);

  localparam int CW = cnt_w(DEPTH);
  localparam int IW = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(DEPTH - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  state_e                          state_q, state_d;
  logic [CW-1:0]                   count_q, count_d;
  logic [DEPTH-1:0][WIDTH-1:0]     acc_q, acc_d;
  logic [DEPTH-1:0][WIDTH-1:0]     ins;
  logic                            in_fire, close_pkt, last_word, out_free;
  logic                            ld;
  logic [DEPTH-1:0][WIDTH-1:0]     ld_data;
  logic [CW-1:0]                   ld_count;

`ifdef LANE_PACK_FLUSH_EN
  assign last_word = in_last;
`else
  assign last_word = 1'b0;
`endif

  assign in_ready  = (state_q == FILL) && !arst;
  assign in_fire   = in_valid && in_ready;
  // Packet closes on the DEPTH-th word or on an early in_last.
  assign close_pkt = (count_q == LAST_IDX) || last_word;

  // Accumulator/FSM next state and load request to the holding register.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    acc_d    = acc_q;
    ld       = 1'b0;
    ld_data  = acc_q;
    ld_count = count_q;
    ins      = acc_q;
    ins[count_q[IW-1:0]] = in_data;
    case (state_q)
      FILL: begin
        if (in_fire) begin
          if (close_pkt && out_free) begin
            // Zero-bubble path: straight into the output register.
            ld       = 1'b1;
            ld_data  = ins;
            ld_count = count_q + ONE;
            acc_d    = '0;
            count_d  = '0;
          end else begin
            acc_d   = ins;
            count_d = count_q + ONE;
            if (close_pkt) state_d = FULL;
          end
        end
      end
      FULL: begin
        // Output register only frees up via out_fire here.
        if (out_free) begin
          ld       = 1'b1;
          ld_data  = acc_q;
          ld_count = count_q;
          acc_d    = '0;
          count_d  = '0;
          state_d  = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // Accumulator and FSM registers; reset discards any partial packet.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= FILL;
      count_q <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
    end
  end

  lane_pack_out_reg #(
    .W  (WIDTH*DEPTH),
    .CW (CW)
  ) u_out (
    .clk          (clk),
    .arst         (arst),
    .load_i       (ld),
    .load_data_i  (ld_data),
    .load_count_i (ld_count),
    .out_ready_i  (out_ready),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .out_count_o  (out_count),
    .out_free_o   (out_free)
  );

endmodule

// File: tb/tb_lane_pack_deser.sv
// Self-checking bench for lane_pack_deser: directed scenarios followed by a
// randomly throttled stream checked against a packet scoreboard.
module tb_lane_pack_deser;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int NWORDS = 1000;

  logic                   clk = 1'b0;
  logic                   arst;
  logic                   in_valid, in_ready;
  logic [WIDTH-1:0]       in_data;
`ifdef LANE_PACK_FLUSH_EN
  logic                   in_last;
`endif
  logic                   out_valid, out_ready;
  logic [WIDTH*DEPTH-1:0] out_data;
  logic [CW-1:0]          out_count;

  int n_tests = 0;
  int n_fail  = 0;

  lane_pack_deser #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .arst      (arst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef LANE_PACK_FLUSH_EN
    .in_last   (in_last),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send words lo..hi back to back (in_ready checked before each).
  task automatic send_seq(input string tag, input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      in_valid = 1'b1;
      in_data  = 4'(k);
      chk({tag, "_rdy"}, in_ready, 1);
      tick();
    end
    in_valid = 1'b0;
  endtask

  logic [WIDTH-1:0] cur[$];
  logic [63:0]      exp_d[$];
  int               exp_c[$];
  logic [63:0]      pkt;
  logic             pv, pr, lst;
  logic [63:0]      pd, pc;
  int               acc_words, cycles, n_pkts, n_out;

  initial begin
    arst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
`ifdef LANE_PACK_FLUSH_EN
    in_last = 1'b0;
`endif
    tick(); tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data",  out_data, 0);
    chk("rst_count", out_count, 0);
    chk("rst_rdy",   in_ready, 0);
    arst = 1'b0;
    tick();
    chk("post_rst_rdy", in_ready, 1);

    // Single packet, sink always ready; result one cycle after 4th word.
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 4'(k);
      chk("t1_rdy", in_ready, 1);
      chk("t1_noval", out_valid, 0);
      tick();
    end
    in_valid = 1'b0;
    chk("t1_valid", out_valid, 1);
    chk("t1_data",  out_data, 16'h4321);
    chk("t1_count", out_count, 4);
    tick();
    chk("t1_drain", out_valid, 0);
    chk("t1_hold",  out_data, 16'h4321);

    // Back-to-back 8 words, no bubble.
    for (int k = 1; k <= 8; k++) begin
      in_valid = 1'b1; in_data = 4'(k);
      chk("t2_rdy", in_ready, 1);
      tick();
      if (k == 4) chk("t2_pkt0", out_data, 16'h4321);
      if (k == 5) chk("t2_drain", out_valid, 0);
    end
    in_valid = 1'b0;
    chk("t2_valid", out_valid, 1);
    chk("t2_pkt1",  out_data, 16'h8765);
    tick();

    // Stalled sink: second packet parks in FULL.
    out_ready = 1'b0;
    send_seq("t3", 1, 8);
    chk("t3_full_rdy", in_ready, 0);
    chk("t3_valid",    out_valid, 1);
    chk("t3_held",     out_data, 16'h4321);
    in_valid = 1'b1; in_data = 4'h9;
    tick();
    in_valid = 1'b0;
    chk("t3_still_rdy", in_ready, 0);
    chk("t3_stable",    out_data, 16'h4321);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("t3_pkt1",  out_data, 16'h8765);
    chk("t3_val1",  out_valid, 1);
    chk("t3_cnt1",  out_count, 4);
    chk("t3_rdy_back", in_ready, 1);

    // Async reset mid-packet discards the partial accumulator.
    send_seq("t4", 10, 11);
    #3 arst = 1'b1;
    #1;
    chk("t4_valid", out_valid, 0);
    chk("t4_data",  out_data, 0);
    chk("t4_count", out_count, 0);
    chk("t4_rdy",   in_ready, 0);
    tick();
    arst = 1'b0;
    out_ready = 1'b1;
    tick();
    send_seq("t4b", 1, 4);
    chk("t4_pkt",   out_data, 16'h4321);
    chk("t4_cnt",   out_count, 4);
    tick();

`ifdef LANE_PACK_FLUSH_EN
    // Early close with in_last.
    in_valid = 1'b1; in_data = 4'h5; tick();
    in_data = 4'h6; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    chk("fl_data",  out_data, 16'h0065);
    chk("fl_count", out_count, 2);
    tick();
    send_seq("fl2", 1, 4);
    chk("fl2_data",  out_data, 16'h4321);
    chk("fl2_count", out_count, 4);
    tick();
`endif

    // Random throttling against a packet scoreboard.
    acc_words = 0; cycles = 0; n_pkts = 0; n_out = 0;
    pv = 1'b0; pr = 1'b0; pd = '0; pc = '0;
    while ((acc_words < NWORDS || exp_d.size() != 0) && cycles < 20000) begin
      in_valid  = (acc_words < NWORDS) && ($urandom_range(0, 3) != 0);
      in_data   = 4'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      lst = 1'b0;
`ifdef LANE_PACK_FLUSH_EN
      in_last = ($urandom_range(0, 7) == 0);
      lst = in_last;
`endif
      if (pv && !pr) begin
        chk("rnd_stable_d", out_data, pd);
        chk("rnd_stable_c", out_count, pc);
      end
      if (out_valid && out_ready) begin
        chk("rnd_expected", (exp_d.size() != 0), 1);
        if (exp_d.size() != 0) begin
          chk("rnd_data",  out_data, exp_d.pop_front());
          chk("rnd_count", out_count, exp_c.pop_front());
          n_out++;
        end
      end
      if (in_valid && in_ready) begin
        cur.push_back(in_data);
        acc_words++;
        if (cur.size() == DEPTH || lst) begin
          pkt = '0;
          foreach (cur[i]) pkt |= 64'(cur[i]) << (i * WIDTH);
          exp_d.push_back(pkt);
          exp_c.push_back(cur.size());
          cur.delete();
          n_pkts++;
        end
      end
      pv = out_valid; pr = out_ready; pd = out_data; pc = out_count;
      tick();
      cycles++;
    end
    in_valid = 1'b0;
    chk("rnd_timeout",  (cycles < 20000), 1);
    chk("rnd_sb_empty", exp_d.size(), 0);
    chk("rnd_npkts",    n_out, n_pkts);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
